rr_arb_mux: RTL and testbench

- Parametrised successor to the combinational select mux.
- Merges 2**N valid/ready input channels of W-bit data onto one registered output channel.
- Default arbitration is round-robin; a forced-select mode pins the grant to one channel, giving classic select-mux behaviour.
- Sits in front of shared sinks (bus ports, UART TX, display drivers) where several producers contend.

---
 rtl/rr_arb_pkg.sv | 18 +
 rtl/rr_arb_mux_picker.sv | 32 +++
 rtl/rr_arb_mux.sv | 82 ++++++++
 tb/tb_rr_arb_mux.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared helpers for the round-robin arbiter family: index width,
// pointer reset value and per-channel data slicing.
package rr_arb_pkg;

  function automatic int idx_w(input int n);
    return (n < 1) ? 1 : n;
  endfunction

  // Pointer starts on the last channel so the first search begins at 0.
  function automatic int ptr_rst(input int n);
    return (1 << n) - 1;
  endfunction

  function automatic int lane_lo(input int i, input int w);
    return i * w;
  endfunction

endpackage

// File: rtl/rr_arb_mux_picker.sv
// Combinational round-robin picker: rotate the request vector past the
// pointer, priority-encode, then un-rotate back to a channel index.
module rr_picker
  import rr_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [(1<<N)-1:0] i_req,
  input  logic [N-1:0]      i_ptr,
  output logic [N-1:0]      o_idx,
  output logic              o_vld
);

  localparam int C  = 1 << N;
  localparam int IW = idx_w(N);

  logic [C-1:0]  w_rot;
  logic [IW-1:0] w_off;

  always_comb begin
    w_rot = '0;
    // Index arithmetic is N bits wide, so the wrap mod C is free.
    for (int j = 0; j < C; j++)
      w_rot[j] = i_req[i_ptr + IW'(1) + IW'(j)];
    w_off = '0;
    for (int j = C - 1; j >= 0; j--)
      if (w_rot[j]) w_off = IW'(j);
    o_vld = |i_req;
    o_idx = i_ptr + IW'(1) + w_off;
  end

endmodule

// File: rtl/rr_arb_mux.sv
// Merges 2**N valid/ready channels onto one registered output, round-robin
// by default or pinned to force_sel in forced mode.
module rr_arb_mux
  import rr_arb_pkg::*;
#(
  parameter int N = 2,
  parameter int W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [(1<<N)*W-1:0]   in_data,
  input  logic [(1<<N)-1:0]     in_valid,
  output logic [(1<<N)-1:0]     in_ready,
  input  logic                  force_en,
  input  logic [N-1:0]          force_sel,
  output logic [W-1:0]          out_data,
  output logic                  out_valid,
  output logic [N-1:0]          out_sel,
  input  logic                  out_ready
);

  localparam int C  = 1 << N;
  localparam int IW = idx_w(N);

  logic [W-1:0]  r_data;
  logic          r_valid;
  logic [IW-1:0] r_sel;
  logic [IW-1:0] r_ptr;

  logic          w_load;
  logic [IW-1:0] w_rr_idx;
  logic          w_rr_vld;
  logic [IW-1:0] w_g;
  logic          w_gv;
  logic [W-1:0]  w_gdata;

  rr_picker #(.N(N)) u_picker (
    .i_req (in_valid),
    .i_ptr (r_ptr),
    .o_idx (w_rr_idx),
    .o_vld (w_rr_vld)
  );

  assign w_load = !r_valid || out_ready;
  assign w_g    = force_en ? force_sel : w_rr_idx;
  assign w_gv   = force_en ? in_valid[force_sel] : w_rr_vld;

  always_comb begin
    w_gdata = '0;
    for (int i = 0; i < C; i++)
      if (w_g == IW'(i)) w_gdata = in_data[lane_lo(i, W) +: W];
  end

  always_comb begin
    in_ready = '0;
    if (!rst && w_load && w_gv) in_ready[w_g] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_sel   <= '0;
      r_ptr   <= IW'(ptr_rst(N));
    end else if (w_load) begin
      if (w_gv) begin
        r_data  <= w_gdata;
        r_sel   <= w_g;
        r_valid <= 1'b1;
        r_ptr   <= w_g;
      end else begin
        // No grant: drop valid, keep the last word visible for debug.
        r_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign out_sel   = r_sel;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed scoreboard bench for rr_arb_mux (N=2, W=8).
module tb_rr_arb_mux;

  localparam int N = 2;
  localparam int W = 8;
  localparam int C = 1 << N;

  logic              clk = 1'b0;
  logic              rst;
  logic [C*W-1:0]    in_data;
  logic [C-1:0]      in_valid;
  logic [C-1:0]      in_ready;
  logic              force_en;
  logic [N-1:0]      force_sel;
  logic [W-1:0]      out_data;
  logic              out_valid;
  logic [N-1:0]      out_sel;
  logic              out_ready;

  int vectors = 0;
  int miscompares = 0;
  logic [N+W-1:0] sb[$];

  rr_arb_mux #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .force_en  (force_en),
    .force_sel (force_sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int i, input logic [W-1:0] v);
    in_data[i*W +: W] = v;
  endtask

  task automatic push(input int sel, input logic [W-1:0] d);
    sb.push_back({N'(sel), d});
  endtask

  task automatic check_out(input string tag);
    logic [N+W-1:0] e;
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL %s.sb: got output %0h with scoreboard empty, expected none", tag, out_data);
    end else begin
      e = sb.pop_front();
      chk({tag, ".sel"},  32'(out_sel),  32'(e[N+W-1:W]));
      chk({tag, ".data"}, 32'(out_data), 32'(e[W-1:0]));
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = '1; out_ready = 1'b1;
    force_en = 1'b0; force_sel = '0;
    for (int i = 0; i < C; i++) set_ch(i, 8'hA0 + 8'(i));

    // 1: reset with all channels valid
    #1;
    chk("rst.ready0", 32'(in_ready), 32'h0);
    tick();
    chk("rst.ready1", 32'(in_ready), 32'h0);
    chk("rst.valid1", 32'(out_valid), 32'h0);
    chk("rst.data1", 32'(out_data), 32'h0);
    chk("rst.sel1", 32'(out_sel), 32'h0);
    tick();
    chk("rst.ready2", 32'(in_ready), 32'h0);
    chk("rst.valid2", 32'(out_valid), 32'h0);
    rst = 1'b0;
    #1;
    chk("rel.ready", 32'(in_ready), 32'h1);

    // 2: full contention, grants 0,1,2,3,0,1 with no bubbles
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("rr.ready%0d", k), 32'(in_ready), 32'(1 << (k % C)));
      push(k % C, 8'hA0 + 8'(k % C));
      tick();
      check_out($sformatf("rr%0d", k));
    end

    // 3: backpressure while holding A1
    out_ready = 1'b0;
    #1;
    chk("bp.ready", 32'(in_ready), 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("bp.valid%0d", k), 32'(out_valid), 32'h1);
      chk($sformatf("bp.data%0d", k), 32'(out_data), 32'hA1);
      chk($sformatf("bp.sel%0d", k), 32'(out_sel), 32'h1);
      chk($sformatf("bp.ready%0d", k), 32'(in_ready), 32'h0);
    end
    out_ready = 1'b1;
    push(2, 8'hA2);
    tick();
    check_out("bp.rel");

    // 4: sparse channel 3 back-to-back, then wrap to channel 0
    in_valid = 4'b1000;
    set_ch(3, 8'h5C);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("sp.ready%0d", k), 32'(in_ready), 32'h8);
      push(3, 8'h5C);
      tick();
      check_out($sformatf("sp%0d", k));
    end
    in_valid = 4'b0001;
    push(0, 8'hA0);
    tick();
    check_out("wrap");

    // 5: forced mode
    set_ch(3, 8'hA3);
    force_en = 1'b1; force_sel = 2'd2; in_valid = 4'b1011;
    #1;
    chk("frc.ready", 32'(in_ready), 32'h0);
    tick();
    chk("frc.idle", 32'(out_valid), 32'h0);
    in_valid = 4'b1111;
    #1;
    chk("frc.ready2", 32'(in_ready), 32'h4);
    push(2, 8'hA2);
    tick();
    check_out("frc.grant");
    force_en = 1'b0;
    push(3, 8'hA3);
    tick();
    check_out("frc.resume");

    // 6: reset mid-stream while holding 77
    in_valid = 4'b0001;
    set_ch(0, 8'h77);
    push(0, 8'h77);
    tick();
    check_out("mid.load");
    rst = 1'b1; in_valid = 4'b1111;
    #1;
    chk("mid.ready", 32'(in_ready), 32'h0);
    tick();
    chk("mid.valid", 32'(out_valid), 32'h0);
    chk("mid.data", 32'(out_data), 32'h0);
    rst = 1'b0;
    #1;
    chk("mid.ready2", 32'(in_ready), 32'h1);
    push(0, 8'h77);
    tick();
    check_out("mid.first");

    chk("sb.empty", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
